alu_pipelined: RTL
==================

# alu_pipelined

Parametrised, handshaked per-thread arithmetic unit that generalises the core's combinational ALU. It has a configurable data width and a registered result stage, and carries a destination tag through to the result. A compare operation produces the core's {gt, eq, lt} flag word. Divide runs iteratively over several cycles. The block sits between a thread's register-read stage and its writeback stage, one instance per thread lane.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: operand and result width; must be ≥ 3.
- `TAG_WIDTH`, default 4: width of the destination-register tag, passed through unmodified.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request this cycle.
- `in_op` in 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 CMP; 101–111 are illegal.
- `in_rs`, `in_rt` in DATA_WIDTH: operands, unsigned.
- `in_tag` in TAG_WIDTH: destination tag.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_result` out DATA_WIDTH: result.
- `out_tag` out TAG_WIDTH: tag of the request that produced `out_result`.
- `out_div_by_zero` out 1: result is from DIV with `rt == 0`.
- `out_illegal` out 1: result is from an illegal opcode.
- `busy` out 1: iterative divide in progress.

## Operation
- Acceptance occurs when `in_valid && in_ready` is true at a rising edge.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. It is 0 while `reset` is asserted.
- Result `out_valid` clears when `out_valid && out_ready` holds and no new result is written on the same edge.
- All arithmetic is unsigned and truncated to DATA_WIDTH (wrap-around):
  - ADD: low DATA_WIDTH bits of `rs + rt`.
  - SUB: low DATA_WIDTH bits of `rs - rt`.
  - MUL: low DATA_WIDTH bits of the 2·DATA_WIDTH product.
- CMP: `out_result = {(DATA_WIDTH-3)'0, gt, eq, lt}`, where gt = `rs > rt`, eq = `rs == rt`, lt = `rs < rt`.
- DIV: quotient `floor(rs / rt)`; the remainder is discarded.
- DIV with `rt == 0`:
  - `out_result = 0` and `out_div_by_zero = 1`.
  - Completes like a single-cycle op; the FSM never enters DIV.
- Illegal opcode: `out_result = 0` and `out_illegal = 1`; completes like a single-cycle op.
- Flags are 0 for every other result.
- FSM has two states, IDLE and DIV:
  - IDLE → DIV on accepting DIV with `rt != 0`. On that edge the divider loads the dividend, the divisor and a zeroed partial remainder, and step count = DATA_WIDTH.
  - In DIV, each edge performs one restoring step, MSB first, and decrements the count.
  - On the edge where the count goes 1→0, the quotient and tag are written to the result register, `out_valid` is set, and the state returns to IDLE.
- No hold state is needed. The result register is guaranteed empty when DIV finishes, because no request is accepted while in DIV.
- `busy = (state == DIV)`.

## Timing
- Reset values: `out_valid` 0, `out_result` 0, `out_tag` 0, both flags 0, `busy` 0, state IDLE. `in_ready` becomes 1 in the first cycle after deassertion.
- Single-cycle ops (ADD, SUB, MUL, CMP, DIV-by-zero, illegal):
  - Latency: accepted in cycle N, result visible in cycle N+1.
  - Throughput: one per cycle when `out_ready` is held at 1.
- DIV with `rt != 0`:
  - Latency: accepted in cycle N, `out_valid` in cycle N+DATA_WIDTH+1.
  - `in_ready` is 0 for cycles N+1 … N+DATA_WIDTH.
- Backpressure: while `out_valid && !out_ready`, the outputs are held stable and `in_ready` is 0.
- Simultaneous drain and accept: when `out_ready` and a new acceptance occur on the same edge, the new result replaces the old one and `out_valid` stays 1.
- Reset mid-divide:
  - The divide is aborted immediately and its result is lost.
  - `busy` and `out_valid` drop asynchronously.
  - No stale result appears after reset.
- Operand and tag inputs are sampled only on the accepting edge. Changes during DIV have no effect.

## Structure
- Shared package `alu_pkg`:
  - Op encoding enum `alu_op_t` (ADD, SUB, MUL, DIV, CMP).
  - FSM state enum.
  - CMP bit positions as localparams: GT = 2, EQ = 1, LT = 0.
- One sub-module, `alu_divider`:
  - Iterative restoring divider parametrised by DATA_WIDTH.
  - Interface: start, dividend, divisor, done, quotient.
  - Owns the partial remainder, the quotient shift register and the step counter.
- The top level holds the FSM, the single-cycle datapath, the result register and the handshake logic.

## Test plan
All scenarios use DATA_WIDTH = 8 and TAG_WIDTH = 4.
- ADD 200+100, tag 5 → `out_result` 44, `out_tag` 5, `out_valid` one cycle after accept; SUB 3−5 → 254; MUL 20×13 → 4.
- DIV 200/7, tag 9 → 28, `busy` high 8 cycles, `out_valid` 9 cycles after accept, `in_ready` 0 throughout; DIV 5/0 → 0, `out_div_by_zero` 1, latency 1, `busy` never rises.
- CMP 5 vs 9 → 8'b0000_0001; 9 vs 9 → 8'b0000_0010; 200 vs 3 → 8'b0000_0100; op 110 → 0 with `out_illegal` 1.
- Back-to-back ADDs 1+1, 2+2, 3+3 with `out_ready` = 1 → results 2, 4, 6 on consecutive cycles; then `out_ready` = 0 for 3 cycles → result 6 held stable, `in_ready` 0, then drains.
- Reset asserted at the 4th step of DIV 255/3 → `out_valid` and `busy` 0 immediately, no result after deassertion; next ADD 1+2 → 3 with normal latency.
- Randomised ops on all widths with a reference model, including DATA_WIDTH = 16 with DIV 65535/255 → 257, 17-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined per-thread ALU: opcodes, FSM states
// and the bit positions of the compare flag word.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_CMP = 3'b100
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } alu_state_t;

    localparam int unsigned CMP_GT = 2;
    localparam int unsigned CMP_EQ = 1;
    localparam int unsigned CMP_LT = 0;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// done/quotient describe the step being taken on the current edge.
module alu_divider
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;
    logic [DATA_WIDTH-1:0] rem_next, quo_next;

    // The remainder stays below the divisor, so the shifted value needs one
    // extra bit and the subtraction only needs DATA_WIDTH bits.
    always_comb begin
        shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
        ge       = (shifted >= {1'b0, dsr_q});
        rem_next = ge ? (shifted[DATA_WIDTH-1:0] - dsr_q) : shifted[DATA_WIDTH-1:0];
        quo_next = {quo_q[DATA_WIDTH-2:0], ge};
    end

    assign done     = (cnt_q == CW'(1));
    assign quotient = quo_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CW'(DATA_WIDTH);
        end else if (cnt_q != '0) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipelined.sv
// Handshaked per-thread ALU with a registered result stage; single-cycle
// ADD/SUB/MUL/CMP and an iterative DIV, carrying a destination tag through.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_rs,
    input  logic [DATA_WIDTH-1:0] in_rt,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_div_by_zero,
    output logic                  out_illegal,
    output logic                  busy
);

    alu_state_t            state_q, state_d;
    logic                  accept, div_start, div_done;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] sc_result;
    logic                  sc_dbz, sc_ill;
    logic [TAG_WIDTH-1:0]  div_tag_q;

    assign in_ready  = !reset && (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (in_op == OP_DIV) && (in_rt != '0);
    assign busy      = (state_q == ST_DIV);

    always_comb begin
        sc_result = '0;
        sc_dbz    = 1'b0;
        sc_ill    = 1'b0;
        case (in_op)
            OP_ADD: sc_result = in_rs + in_rt;
            OP_SUB: sc_result = in_rs - in_rt;
            OP_MUL: sc_result = in_rs * in_rt;
            OP_DIV: sc_dbz    = (in_rt == '0);
            OP_CMP: begin
                sc_result[CMP_GT] = (in_rs > in_rt);
                sc_result[CMP_EQ] = (in_rs == in_rt);
                sc_result[CMP_LT] = (in_rs < in_rt);
            end
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (div_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    alu_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (in_rs),
        .divisor  (in_rt),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          div_tag_q <= '0;
        else if (div_start) div_tag_q <= in_tag;
    end

    // A divide start drains the old result without writing a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_tag         <= '0;
            out_div_by_zero <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (state_q == ST_DIV && div_done) begin
            out_valid       <= 1'b1;
            out_result      <= div_quotient;
            out_tag         <= div_tag_q;
            out_div_by_zero <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (accept && !div_start) begin
            out_valid       <= 1'b1;
            out_result      <= sc_result;
            out_tag         <= in_tag;
            out_div_by_zero <= sc_dbz;
            out_illegal     <= sc_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
